serial_full_adder: RTL and testbench
====================================

// Module: serial_full_adder
// PURPOSE
// Bit-serial adder, the additive counterpart of the team's full subtractor cell.
// - Captures two WIDTH-bit operands and a carry-in on a start request.
// - Adds them LSB-first, one bit per clock, through a single full-adder slice and a carry flip-flop.
// - Returns the registered sum and carry-out with a one-cycle done pulse.
// - Serves as the area-minimal adder for the arithmetic datapath.
// PARAMETERS
// WIDTH   8   operand/sum width in bits; legal range >= 1
// PORTS
// clk    in   1      rising-edge clock; the only clock
// rst    in   1      asynchronous, active-high reset
// start  in   1      request; sampled only in IDLE
// a      in   WIDTH  addend A; captured on accepted start
// b      in   WIDTH  addend B; captured on accepted start
// cin    in   1      carry-in; captured on accepted start
// busy   out  1      high while state == RUN
// done   out  1      one-cycle pulse; sum/cout valid in this cycle
// sum    out  WIDTH  registered result; holds until next completion
// cout   out  1      registered carry-out; holds until next completion
// BEHAVIOUR
// - Reset (async assert, any state): state=IDLE, busy=0, done=0, sum=0, cout=0.
//   Also clears internal shift regs, carry FF and bit counter.
//   An operation in flight is abandoned and produces no done pulse.
// - FSM states: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 at edge E0 captures a, b, cin into shift regs A_sh, B_sh and carry FF c. Counter=0, go RUN.
//     start=0: remain IDLE.
//   - RUN: each edge processes bit i = counter.
//     - s_i = A_sh[0]^B_sh[0]^c.
//     - c <= (A_sh[0]&B_sh[0]) | (A_sh[0]&c) | (B_sh[0]&c).
//     - A_sh, B_sh shift right by 1.
//     - s_i enters the MSB of internal shift reg S_sh, which shifts right.
//     - counter increments.
//   - On the edge that processes bit WIDTH-1:
//     - sum <= final S_sh contents, cout <= final carry, done <= 1.
//     - state -> DONE.
//   - DONE: done=1 for exactly this cycle; next edge -> IDLE, done=0.
// - Latency: start sampled at E0; done high during the cycle after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
// - Throughput: one operation per WIDTH+2 cycles. A start in DONE is ignored; the next start is accepted in IDLE.
// - start while RUN or DONE: ignored, not queued.
// - a, b, cin may change freely after acceptance; the result depends only on captured values.
// - Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); unsigned, no overflow flag.
// - Counter width: $clog2(WIDTH+1). WIDTH=1 gives exactly one RUN cycle.
// - busy is combinationally (state==RUN); done and sum/cout are registered outputs.
// - sum/cout change only on completion or reset; they are stable through IDLE and RUN of the next operation.
// TESTING
// 1. WIDTH=8: a=8'h25, b=8'h3A, cin=0, start 1 cycle.
//    -> busy high 8 cycles; done 8 cycles after accept; sum=8'h5F, cout=0.
// 2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//    Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
// 3. Start a=8'h10, b=8'h20. Pulse start with a=8'hAA during RUN, and again in the DONE cycle.
//    -> single done, sum=8'h30; the stray starts are ignored.
// 4. Change a/b/cin every cycle after acceptance of a=8'h81, b=8'h7F, cin=0 -> sum=8'h00, cout=1.
// 5. Assert rst asynchronously at bit 4 of an operation.
//    -> busy=0, done=0, sum=0, cout=0 immediately; no done pulse follows.
//    A fresh start then completes normally.
// 6. WIDTH=1: exhaustive 8 combos of a,b,cin.
//    -> {cout,sum} == a+b+cin; done 1 cycle after accept.
//    Plus a random 1000-op WIDTH=8 scoreboard against a+b+cin.

Source files
------------

// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first.
// Produces {cout,sum} = a + b + cin WIDTH cycles after start is accepted.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_nx;
  logic             c;
  logic             s_bit;
  logic             c_nx;
  logic             last;
  logic [CW-1:0]    cnt;

  // Handshake: start is only looked at in IDLE; anything else is dropped,
  // and done is a single-cycle pulse qualifying sum/cout.
  assign s_bit = a_sh[0] ^ b_sh[0] ^ c;
  assign c_nx  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last  = (cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
  assign s_nx  = WIDTH'({s_bit, s_sh} >> 1);
  assign busy  = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        s_sh <= '0;
        c    <= cin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        s_sh <= s_nx;
        c    <= c_nx;
        cnt  <= cnt + CW'(1);
        if (last) begin
          sum  <= s_nx;
          cout <= c_nx;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder: an 8-bit and a 1-bit instance,
// hand-computed vectors, and a randomised scoreboard pass on the 8-bit one.
module tb_serial_full_adder;

  logic       clk;
  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  serial_full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
  endtask

  // lat = edges after the accepting edge until done is seen; -1 on timeout
  task automatic wait_done8(output int lat, output int busy_cyc);
    lat = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy8) busy_cyc++;
      if (done8) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst8 = 1'b1; rst1 = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      n_err++;
      $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
    end
    n_cmp++;
    if ({busy1, done1, sum1, cout1} !== 4'd0) begin
      n_err++;
      $display("FAIL reset1: busy=%b done=%b sum=%b cout=%b, want all 0", busy1, done1, sum1, cout1);
    end
    rst8 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    start_op8(8'h25, 8'h3A, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d, want 8", lat); end
    n_cmp++;
    if (bc !== 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc); end
    n_cmp++;
    if ({cout8, sum8} !== 9'h05F) begin
      n_err++; $display("FAIL basic_result: got %b/%h, want 0/5f", cout8, sum8);
    end
    @(negedge clk);
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse: done=%b busy=%b a cycle later, want 0/0", done8, busy8);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    bit stable;
    start_op8(8'hFF, 8'h01, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if ({cout8, sum8} !== 9'h100) begin
      n_err++; $display("FAIL carry_wrap: got %b/%h, want 1/00", cout8, sum8);
    end
    start_op8(8'hFF, 8'hFF, 1'b1);
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (sum8 !== 8'h00 || cout8 !== 1'b1) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++; $display("FAIL hold_during_run: sum=%h cout=%b, want 00/1", sum8, cout8);
    end
    wait_done8(lat, bc);
    n_cmp++;
    if (lat !== 4) begin n_err++; $display("FAIL b2b_latency: got %0d remaining, want 4", lat); end
    n_cmp++;
    if ({cout8, sum8} !== 9'h1FF) begin
      n_err++; $display("FAIL all_ones_cin: got %b/%h, want 1/ff", cout8, sum8);
    end
  endtask

  task automatic test_stray_start;
    int dones;
    logic [8:0] got;
    dones = 0;
    got = '0;
    start_op8(8'h10, 8'h20, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (k == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA; end
      if (done8) begin
        dones++;
        got = {cout8, sum8};
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA;
      end
    end
    n_cmp++;
    if (dones !== 1) begin n_err++; $display("FAIL stray_done_count: got %0d, want 1", dones); end
    n_cmp++;
    if (got !== 9'h030) begin n_err++; $display("FAIL stray_result: got %h, want 030", got); end
    n_cmp++;
    if (busy8 !== 1'b0 || {cout8, sum8} !== 9'h030) begin
      n_err++; $display("FAIL stray_idle: busy=%b result=%b/%h, want 0 0/30", busy8, cout8, sum8);
    end
  endtask

  task automatic test_input_change;
    int lat;
    lat = -1;
    start_op8(8'h81, 8'h7F, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done8) begin lat = k - 1; break; end
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
    end
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL change_latency: got %0d, want 8", lat); end
    n_cmp++;
    if ({cout8, sum8} !== 9'h100) begin
      n_err++; $display("FAIL change_result: got %b/%h, want 1/00", cout8, sum8);
    end
  endtask

  task automatic test_async_reset;
    int lat, bc, dones;
    start_op8(8'h12, 8'h34, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if ({cout8, sum8} !== 9'h046) begin
      n_err++; $display("FAIL pre_reset_result: got %b/%h, want 0/46", cout8, sum8);
    end
    start_op8(8'h55, 8'h0F, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst8 = 1'b1;
    #1;
    n_cmp++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst8 = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_err++; $display("FAIL abandoned_op: %0d busy/done cycles, want 0", dones); end
    start_op8(8'h55, 8'h0F, 1'b0);
    wait_done8(lat, bc);
    n_cmp++;
    if (lat !== 8 || {cout8, sum8} !== 9'h064) begin
      n_err++; $display("FAIL post_reset_op: lat=%0d result=%b/%h, want 8 0/64", lat, cout8, sum8);
    end
  endtask

  task automatic test_width1;
    int lat;
    logic [1:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      exp_v = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (done1) begin lat = k - 1; break; end
      end
      n_cmp++;
      if (lat !== 1 || {cout1, sum1} !== exp_v) begin
        n_err++;
        $display("FAIL w1_combo%0d: lat=%0d result=%b%b, want 1 %b", i, lat, cout1, sum1, exp_v);
      end
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [7:0] av, bv;
    logic cv;
    logic [8:0] e;
    for (int n = 0; n < 1000; n++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      cv = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op8(av, bv, cv);
      wait_done8(lat, bc);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== 8 || {cout8, sum8} !== e) begin
        n_err++;
        $display("FAIL rand%0d: %h+%h+%b lat=%0d got %b/%h, want 8 %h", n, av, bv, cv, lat, cout8, sum8, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_stray_start;
    test_input_change;
    test_async_reset;
    test_width1;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
